// File: rtl/exe_mem_skid_if.sv
// EXE->MEM stage bus: upstream handshake and payload, downstream head, flush and stall count.
// The stage itself uses the slave modport; the environment uses master.
interface exe_mem_skid_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wb_en_in;
    logic                  mem_r_en_in;
    logic                  mem_w_en_in;
    logic [DATA_W-1:0]     alu_res_in;
    logic [DATA_W-1:0]     store_val_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     store_val;
    logic [REG_ADDR_W-1:0] dest;
    logic [CNT_W-1:0]      stall_cnt;

    modport slave (
        input  flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
               alu_res_in, store_val_in, dest_in, out_ready,
        output in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
               alu_res, store_val, dest, stall_cnt
    );

    modport master (
        output flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
               alu_res_in, store_val_in, dest_in, out_ready,
        input  in_ready, out_valid, wb_en, mem_r_en, mem_w_en,
               alu_res, store_val, dest, stall_cnt
    );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid buffer (head + skid), registered in_ready,
// branch-squash flush and a saturating MEM-stall counter.
module exe_mem_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    exe_mem_skid_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wb;
        logic                  rd;
        logic                  wr;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     st;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    entry_t in_e;
    logic   out_valid;
    logic   accept;
    logic   pop;

    assign in_e      = '{wb: bus.wb_en_in, rd: bus.mem_r_en_in, wr: bus.mem_w_en_in,
                         alu: bus.alu_res_in, st: bus.store_val_in, dest: bus.dest_in};
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    head_d  = in_e;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    head_d = in_e;
                end else if (accept) begin
                    state_d = S_TWO;
                    skid_d  = in_e;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // A squash discards everything, including whatever EXE offered this cycle.
        if (bus.flush) begin
            state_d = S_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end

        if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Controls are masked by the registered state so an empty stage never issues a MEM op.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.wb_en     = head_q.wb & out_valid;
    assign bus.mem_r_en  = head_q.rd & out_valid;
    assign bus.mem_w_en  = head_q.wr & out_valid;
    assign bus.alu_res   = head_q.alu;
    assign bus.store_val = head_q.st;
    assign bus.dest      = head_q.dest;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg: a FIFO scoreboard of accepted entries is checked
// against the head outputs every cycle, together with in_ready, out_valid and stall_cnt.
module tb_exe_mem_skid_reg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic                  wb;
        logic                  rd;
        logic                  wr;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     st;
        logic [REG_ADDR_W-1:0] dest;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt_exp = 0;
    entry_t q[$];

    exe_mem_skid_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

    exe_mem_skid_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t head_obs();
        return {bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.alu_res, bus.store_val, bus.dest};
    endfunction

    function automatic entry_t rnd_e();
        entry_t e;
        e.wb   = 1'($urandom);
        e.rd   = 1'($urandom);
        e.wr   = 1'($urandom);
        e.alu  = $urandom;
        e.st   = $urandom;
        e.dest = REG_ADDR_W'($urandom);
        return e;
    endfunction

    task automatic drive(input logic v, input entry_t e);
        bus.in_valid     = v;
        bus.wb_en_in     = e.wb;
        bus.mem_r_en_in  = e.rd;
        bus.mem_w_en_in  = e.wr;
        bus.alu_res_in   = e.alu;
        bus.store_val_in = e.st;
        bus.dest_in      = e.dest;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(q.size() != 0));
        chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(q.size() < 2));
        chk({tag, "_stall_cnt"}, 128'(bus.stall_cnt), 128'(cnt_exp));
        if (q.size() != 0)
            chk({tag, "_head"}, 128'(head_obs()), 128'(q[0]));
        else
            chk({tag, "_ctrl_idle"}, 128'({bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 128'(0));
        $display("%0t %s: out_valid=%0b in_ready=%0b alu_res=%h dest=%0d stall_cnt=%0d queued=%0d",
                 $time, tag, bus.out_valid, bus.in_ready, bus.alu_res, bus.dest, bus.stall_cnt, q.size());
    endtask

    // One clock: predict pop/accept from the inputs held before the edge, then check after it.
    task automatic tick(input string tag);
        logic acc, pp;
        entry_t in_e;
        @(negedge clk);
        acc  = bus.in_valid && bus.in_ready;
        pp   = bus.out_valid && bus.out_ready;
        in_e = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.alu_res_in, bus.store_val_in, bus.dest_in};
        if (pp && q.size() != 0) begin
            chk({tag, "_pop"}, 128'(head_obs()), 128'(q[0]));
            q.delete(0);
        end
        if (bus.out_valid && !bus.out_ready && cnt_exp != 15) cnt_exp++;
        if (bus.flush) q.delete();
        else if (acc) q.push_back(in_e);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        entry_t e;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0);

        // Reset state
        #12;
        check_state("reset");
        chk("reset_alu", 128'(bus.alu_res), 128'(0));
        chk("reset_dest", 128'(bus.dest), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single item, one-cycle latency
        e = '0; e.alu = 32'h10; e.dest = 4'd3; e.wb = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, e);
        tick("t1_acc");
        chk("t1_alu", 128'(bus.alu_res), 128'(32'h10));
        chk("t1_dest", 128'(bus.dest), 128'(3));
        drive(1'b0, '0);
        tick("t1_drain");

        // 3: back-to-back streaming, 8 items, out_ready held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rnd_e());
            tick("t3_stream");
        end
        drive(1'b0, '0);
        tick("t3_drain");
        chk("t3_no_stall", 128'(bus.stall_cnt), 128'(0));

        // 2: A, B fill head and skid; C is held off until space frees
        bus.out_ready = 1'b0;
        drive(1'b1, rnd_e());
        tick("t2_a");
        drive(1'b1, rnd_e());
        tick("t2_b");
        chk("t2_full", 128'(bus.in_ready), 128'(0));
        drive(1'b1, rnd_e());
        tick("t2_c_held");
        tick("t2_c_held2");
        bus.out_ready = 1'b1;
        tick("t2_pop_a");
        tick("t2_pop_b_acc_c");
        drive(1'b0, '0);
        tick("t2_pop_c");

        // 4: flush from TWO with a valid input that must be discarded
        bus.out_ready = 1'b0;
        drive(1'b1, rnd_e());
        tick("t4_fill1");
        drive(1'b1, rnd_e());
        tick("t4_fill2");
        drive(1'b1, rnd_e());
        bus.flush = 1'b1;
        tick("t4_flush");
        bus.flush = 1'b0;
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        tick("t4_after1");
        tick("t4_after2");

        // 5: long stall saturates the counter; flush leaves it alone
        bus.out_ready = 1'b0;
        drive(1'b1, rnd_e());
        tick("t5_load");
        drive(1'b0, '0);
        for (int i = 0; i < 19; i++) tick("t5_stall");
        chk("t5_sat", 128'(bus.stall_cnt), 128'(15));
        bus.flush = 1'b1;
        tick("t5_flush");
        bus.flush = 1'b0;
        chk("t5_sat_kept", 128'(bus.stall_cnt), 128'(15));

        // 6: async reset mid-cycle while in TWO
        drive(1'b1, rnd_e());
        tick("t6_fill1");
        drive(1'b1, rnd_e());
        tick("t6_fill2");
        drive(1'b0, '0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        cnt_exp = 0;
        chk("t6_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("t6_rst_ready", 128'(bus.in_ready), 128'(1));
        chk("t6_rst_ctrl", 128'({bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 128'(0));
        chk("t6_rst_data", 128'({bus.alu_res, bus.store_val, bus.dest}), 128'(0));
        chk("t6_rst_cnt", 128'(bus.stall_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, rnd_e());
        tick("t6_post_acc");
        drive(1'b0, '0);
        tick("t6_post_pop");
        chk("t6_alone", 128'(bus.out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
